// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Build option: define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_src;
    logic [CW-1:0]     r_cnt;
    logic              r_op_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic              r_ovf;

    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_in_dz;
    logic              w_in_ovf;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_res;

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;

    // Operand classification at accept time
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & dividend[XLEN-1];
    assign w_b_neg  = w_signed & divisor[XLEN-1];
    assign w_in_dz  = (divisor == '0);
    assign w_in_ovf = w_signed && (dividend == MIN_NEG) && (divisor == '1);

    // Restoring step; XLEN+1-bit trial subtract keeps the shifted-out bit
    assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? XLEN'(w_diff) : XLEN'(w_rem_sh);

    // Final result with RISC-V special-case overrides
    always_comb begin
        w_res = '0;
        if (r_dz) begin
            w_res = r_op_rem ? r_src : '1;
        end else if (r_ovf) begin
            w_res = r_op_rem ? '0 : r_src;
        end else if (r_op_rem) begin
            w_res = r_neg_r ? -r_rem : r_rem;
        end else begin
            w_res = r_neg_q ? -r_q : r_q;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (w_in_dz || w_in_ovf) begin
                        w_state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    // Datapath; DONE spends its first cycle registering the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_src       <= '0;
            r_cnt       <= '0;
            r_op_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_rem <= op[1];
                        r_q      <= w_a_neg ? -dividend : dividend;
                        r_dvs    <= w_b_neg ? -divisor : divisor;
                        r_src    <= dividend;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= w_in_dz;
                        r_ovf    <= w_in_ovf;
                        r_rem    <= '0;
                        r_cnt    <= CW'(XLEN - 1);
                    end
                end
                S_CALC: begin
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_result    <= w_res;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_result    <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit at XLEN=32.
module tb_div_unit;
    localparam int unsigned XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single cycle; returns #1 after the accept edge
    task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        chk("in_ready_before_issue", 64'(in_ready), 64'd1);
        op       = o;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        issue(o, a, b);
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(out_result), 64'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_valid_one_cycle"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [XLEN-1:0] held;
        rst = 1'b1; in_valid = 1'b0; op = '0; dividend = '0; divisor = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", 64'(out_result), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("div_100_5",     OP_DIV,  32'd100,        32'd5,          32'd20,         NORM_LAT);
        run_op("div_m7_2",      OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT);
        run_op("rem_m7_2",      OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT);
        run_op("remu_fff9_2",   OP_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          NORM_LAT);
        run_op("divu_ffff_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORM_LAT);
        run_op("div_7_m2",      OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORM_LAT);
        run_op("rem_7_m2",      OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT);
        run_op("divu_7_10",     OP_DIVU, 32'd7,          32'd10,         32'd0,          NORM_LAT);
        run_op("remu_7_10",     OP_REMU, 32'd7,          32'd10,         32'd7,          NORM_LAT);
        run_op("divu_5_0",      OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        run_op("rem_5_0",       OP_REM,  32'd5,          32'd0,          32'd5,          SPEC_LAT);
        run_op("rem_m5_0",      OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  SPEC_LAT);
        run_op("div_m5_0",      OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  SPEC_LAT);
        run_op("div_ovf",       OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT);
        run_op("rem_ovf",       OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT);
        run_op("divu_no_ovf",   OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORM_LAT);

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd1000, 32'd7);
        chk("bp_busy", 64'(busy), 64'd1);
        wait_valid(lat);
        chk("bp_latency", 64'(lat), 64'(NORM_LAT));
        held = out_result;
        chk("bp_result", 64'(held), 64'd142);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
            chk("bp_result_hold", 64'(out_result), 64'd142);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Flush on the 10th CALC cycle
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // Flush wins over in_valid in the same cycle
        op = OP_DIV; dividend = 32'd9; divisor = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_beats_in_valid", 64'(busy), 64'd0);
        run_op("div_42_6", OP_DIV, 32'd42, 32'd6, 32'd7, NORM_LAT);

        // Asynchronous reset mid-CALC
        issue(OP_REMU, 32'd100, 32'd3);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_result", 64'(out_result), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op("remu_17_5", OP_REMU, 32'd17, 32'd5, 32'd2, NORM_LAT);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
